// File: rtl/serial_deframer.sv
// Purpose : serial bit-stream deframer; hunts for a sync word, then slices FRAME_LEN bytes MSB-first.
// Latency : a completed byte shows on data_o/valid_o one cycle after the bit_en that finished it.
// Backpr. : 1-deep output buffer; a byte that completes while the buffer is held is dropped (ovf_o).
//
// Ports:
//   c         clock, rising edge
//   rst_n     asynchronous active-low reset
//   bit_in    serial line bit, sampled only when bit_en=1
//   bit_en    bit qualifier; bit_en=0 freezes the framer (handshake still runs)
//   flush     synchronous abort back to sync hunting; overrides bit_en
//   data_o    received byte
//   valid_o   data_o holds an unconsumed byte
//   ready_i   consumer accept; transfer when valid_o & ready_i
//   locked_o  high while slicing data bytes
//   sof_o     one-cycle pulse as the framer locks
//   ovf_o     one-cycle pulse when a completed byte is dropped
module serial_deframer #(
  parameter logic [7:0]  SYNC_PAT  = 8'hA5,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_en,
  input  logic       flush,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       locked_o,
  output logic       sof_o,
  output logic       ovf_o
);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  // Index of the final byte of a frame, compared against the running byte count.
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state, state_nxt;

  // Sync search: bit history plus a saturating count of bits taken since HUNT entry,
  // so a pattern can only match once 8 fresh bits have been seen.
  logic [7:0] hist, hist_nxt;
  logic [3:0] fill, fill_nxt;

  // Data slicing.
  logic [7:0] sreg, sreg_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;

  // Output buffer and pulses.
  logic [7:0] data_nxt;
  logic       valid_nxt;
  logic       sof_nxt;
  logic       ovf_nxt;

  logic [7:0] hist_shift;
  logic [3:0] fill_inc;
  logic [7:0] byte_val;
  logic       xfer;
  logic       byte_done;
  logic       last_byte;

  assign hist_shift = {hist[6:0], bit_in};
  assign fill_inc   = (fill == 4'd8) ? fill : fill + 4'd1;
  assign byte_val   = {sreg[6:0], bit_in};
  assign xfer       = valid_o & ready_i;
  assign byte_done  = (state == DATA) & bit_en & ~flush & (bit_cnt == 3'd7);
  assign last_byte  = (byte_cnt == LAST_IDX);
  assign locked_o   = (state == DATA);

  // ------------------------------------------------------------------
  // Framer state register
  // ------------------------------------------------------------------
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      hist     <= 8'h00;
      fill     <= 4'd0;
      sreg     <= 8'h00;
      bit_cnt  <= 3'd0;
      byte_cnt <= 8'h00;
    end else begin
      state    <= state_nxt;
      hist     <= hist_nxt;
      fill     <= fill_nxt;
      sreg     <= sreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Framer next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    hist_nxt     = hist;
    fill_nxt     = fill;
    sreg_nxt     = sreg;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    sof_nxt      = 1'b0;

    if (flush) begin
      state_nxt    = HUNT;
      hist_nxt     = 8'h00;
      fill_nxt     = 4'd0;
      sreg_nxt     = 8'h00;
      bit_cnt_nxt  = 3'd0;
      byte_cnt_nxt = 8'h00;
    end else if (bit_en) begin
      unique case (state)
        HUNT: begin
          hist_nxt = hist_shift;
          fill_nxt = fill_inc;
          // Match on the value being written, so lock happens on the edge
          // that takes the final sync bit.
          if ((hist_shift == SYNC_PAT) && (fill_inc == 4'd8)) begin
            state_nxt    = DATA;
            bit_cnt_nxt  = 3'd0;
            byte_cnt_nxt = 8'h00;
            sof_nxt      = 1'b1;
          end
        end
        DATA: begin
          sreg_nxt    = byte_val;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            // Dropped bytes still count toward the frame length.
            byte_cnt_nxt = byte_cnt + 8'd1;
            if (last_byte) begin
              // Fill restarts at zero, so no pattern straddles the frame end.
              state_nxt = HUNT;
              hist_nxt  = 8'h00;
              fill_nxt  = 4'd0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Output buffer next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    data_nxt  = data_o;
    valid_nxt = valid_o;
    ovf_nxt   = 1'b0;

    if (flush) begin
      valid_nxt = 1'b0;
    end else begin
      if (xfer) begin
        valid_nxt = 1'b0;
      end
      if (byte_done) begin
        // Accept when empty or draining this cycle; otherwise keep the held
        // byte untouched so data_o stays stable under backpressure.
        if (!valid_o || xfer) begin
          data_nxt  = byte_val;
          valid_nxt = 1'b1;
        end else begin
          ovf_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= 8'h00;
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      data_o  <= data_nxt;
      valid_o <= valid_nxt;
      sof_o   <= sof_nxt;
      ovf_o   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_serial_deframer.sv
module tb_serial_deframer;

  logic       c = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_en;
  logic       flush;
  logic       ready_i;

  logic [7:0] data_o;
  logic       valid_o;
  logic       locked_o;
  logic       sof_o;
  logic       ovf_o;

  logic [7:0] data1;
  logic       valid1;
  logic       locked1;
  logic       sof1;
  logic       ovf1;

  always #5 c = ~c;

  serial_deframer #(.SYNC_PAT(8'hA5), .FRAME_LEN(4)) dut (
    .c        (c),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_en   (bit_en),
    .flush    (flush),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .locked_o (locked_o),
    .sof_o    (sof_o),
    .ovf_o    (ovf_o)
  );

  serial_deframer #(.SYNC_PAT(8'hA5), .FRAME_LEN(1)) dut1 (
    .c        (c),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_en   (bit_en),
    .flush    (flush),
    .data_o   (data1),
    .valid_o  (valid1),
    .ready_i  (ready_i),
    .locked_o (locked1),
    .sof_o    (sof1),
    .ovf_o    (ovf1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer / pulse monitor, sampled on the falling edge.
  logic [7:0] rx[$];
  logic [7:0] rx1[$];
  int sof_cnt  = 0;
  int ovf_cnt  = 0;
  int sof1_cnt = 0;

  always @(negedge c) begin
    if (rst_n) begin
      if (valid_o && ready_i) rx.push_back(data_o);
      if (valid1 && ready_i)  rx1.push_back(data1);
      if (sof_o) sof_cnt++;
      if (ovf_o) ovf_cnt++;
      if (sof1)  sof1_cnt++;
    end
  end

  task automatic clear_mon();
    rx.delete();
    rx1.delete();
    sof_cnt  = 0;
    ovf_cnt  = 0;
    sof1_cnt = 0;
  endtask

  // One bit_en cycle; returns 1 time unit after the sampling edge.
  task automatic sb(input logic b, input logic f);
    bit_in = b;
    bit_en = 1'b1;
    flush  = f;
    @(posedge c);
    #1;
    bit_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) begin
      idle(gap);
      sb(v[i], 1'b0);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    bit_en = 1'b0;
    flush  = 1'b0;
    bit_in = 1'b0;
    repeat (2) @(posedge c);
    #1;
    rst_n = 1'b1;
    clear_mon();
  endtask

  logic [7:0] p;
  logic [7:0] exp4 [4];

  initial begin
    rst_n   = 1'b0;
    bit_in  = 1'b0;
    bit_en  = 1'b0;
    flush   = 1'b0;
    ready_i = 1'b1;
    #2;
    check("rst_data",   {24'd0, data_o}, 32'h00);
    check("rst_valid",  {31'd0, valid_o}, 32'd0);
    check("rst_locked", {31'd0, locked_o}, 32'd0);
    check("rst_sof",    {31'd0, sof_o}, 32'd0);
    check("rst_ovf",    {31'd0, ovf_o}, 32'd0);

    // ---- Basic frame A5 11 22 33 44 ----
    do_reset();
    send_byte(8'hA5, 0);
    check("t1_locked", {31'd0, locked_o}, 32'd1);
    check("t1_sof",    {31'd0, sof_o}, 32'd1);
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      send_byte(exp4[k], 0);
      check("t1_valid", {31'd0, valid_o}, 32'd1);
      check("t1_data",  {24'd0, data_o}, {24'd0, exp4[k]});
    end
    check("t1_unlock", {31'd0, locked_o}, 32'd0);
    idle(2);
    check("t1_rxn", rx.size(), 4);
    if (rx.size() == 4)
      for (int k = 0; k < 4; k++) check("t1_rx", {24'd0, rx[k]}, {24'd0, exp4[k]});
    check("t1_sofn", sof_cnt, 1);
    check("t1_ovfn", ovf_cnt, 0);

    // ---- Seven bits of sync only, then a full sync ----
    do_reset();
    p = 8'hA5;
    for (int i = 6; i >= 0; i--) sb(p[i], 1'b0);
    check("t2_nosync7", {31'd0, locked_o}, 32'd0);
    for (int i = 7; i >= 1; i--) sb(p[i], 1'b0);
    check("t2_nosync14", {31'd0, locked_o}, 32'd0);
    sb(p[0], 1'b0);
    check("t2_sync", {31'd0, locked_o}, 32'd1);
    check("t2_sof",  {31'd0, sof_o}, 32'd1);

    // ---- Backpressure and overflow ----
    do_reset();
    ready_i = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    check("t3_valid", {31'd0, valid_o}, 32'd1);
    check("t3_data1", {24'd0, data_o}, 32'h01);
    check("t3_noovf", {31'd0, ovf_o}, 32'd0);
    send_byte(8'h02, 0);
    check("t3_ovf",   {31'd0, ovf_o}, 32'd1);
    check("t3_hold",  {24'd0, data_o}, 32'h01);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    check("t3_unlock", {31'd0, locked_o}, 32'd0);
    idle(1);
    check("t3_ovfn",  ovf_cnt, 3);
    check("t3_hold2", {24'd0, data_o}, 32'h01);
    ready_i = 1'b1;
    idle(3);
    check("t3_rxn",   rx.size(), 1);
    if (rx.size() == 1) check("t3_rx", {24'd0, rx[0]}, 32'h01);
    check("t3_empty", {31'd0, valid_o}, 32'd0);

    // ---- Flush on the last bit of byte 2 ----
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    p = 8'hC3;
    for (int i = 7; i >= 1; i--) sb(p[i], 1'b0);
    sb(p[0], 1'b1);
    check("t4_novalid", {31'd0, valid_o}, 32'd0);
    check("t4_unlock",  {31'd0, locked_o}, 32'd0);
    check("t4_noovf",   {31'd0, ovf_o}, 32'd0);
    idle(1);
    check("t4_rxn", rx.size(), 1);
    if (rx.size() == 1) check("t4_rx", {24'd0, rx[0]}, 32'h5A);
    send_byte(8'hFF, 0);
    check("t4_still_hunt", {31'd0, locked_o}, 32'd0);
    p = 8'hA5;
    for (int i = 7; i >= 1; i--) sb(p[i], 1'b0);
    check("t4_pre_sync", {31'd0, locked_o}, 32'd0);
    sb(p[0], 1'b0);
    check("t4_resync", {31'd0, locked_o}, 32'd1);
    sb(1'b0, 1'b1);
    check("t4_sofn", sof_cnt, 2);

    // ---- Sparse bit_en, async reset mid-byte, then recovery ----
    do_reset();
    ready_i = 1'b0;
    send_byte(8'hA5, 2);
    send_byte(8'h3C, 2);
    check("t5_valid", {31'd0, valid_o}, 32'd1);
    check("t5_data",  {24'd0, data_o}, 32'h3C);
    idle(2); sb(1'b1, 1'b0);
    idle(2); sb(1'b0, 1'b0);
    idle(2); sb(1'b1, 1'b0);
    idle(2); sb(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_data",   {24'd0, data_o}, 32'h00);
    check("t5_rst_valid",  {31'd0, valid_o}, 32'd0);
    check("t5_rst_locked", {31'd0, locked_o}, 32'd0);
    check("t5_rst_sof",    {31'd0, sof_o}, 32'd0);
    check("t5_rst_ovf",    {31'd0, ovf_o}, 32'd0);
    @(posedge c);
    #1;
    rst_n = 1'b1;
    clear_mon();
    ready_i = 1'b1;
    exp4[0] = 8'h96; exp4[1] = 8'h69; exp4[2] = 8'hC3; exp4[3] = 8'h0F;
    send_byte(8'hA5, 2);
    for (int k = 0; k < 4; k++) send_byte(exp4[k], 2);
    idle(3);
    check("t5_rxn", rx.size(), 4);
    if (rx.size() == 4)
      for (int k = 0; k < 4; k++) check("t5_rx", {24'd0, rx[k]}, {24'd0, exp4[k]});
    check("t5_unlock", {31'd0, locked_o}, 32'd0);
    check("t5_sofn", sof_cnt, 1);

    // ---- Single-byte frames back to back ----
    do_reset();
    send_byte(8'hA5, 0);
    check("t6_lock1", {31'd0, locked1}, 32'd1);
    send_byte(8'h7E, 0);
    check("t6_unlock1", {31'd0, locked1}, 32'd0);
    check("t6_valid1",  {31'd0, valid1}, 32'd1);
    check("t6_data1",   {24'd0, data1}, 32'h7E);
    send_byte(8'hA5, 0);
    send_byte(8'h81, 0);
    idle(2);
    check("t6_rxn", rx1.size(), 2);
    if (rx1.size() == 2) begin
      check("t6_rx0", {24'd0, rx1[0]}, 32'h7E);
      check("t6_rx1", {24'd0, rx1[1]}, 32'h81);
    end
    check("t6_sofn", sof1_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
